// File: rtl/run_detector_pkg.sv
// Shared types for the run detector: channel FSM states and
// the qualifying-rule encodings carried on the mode input.
package run_detector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DETECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_EQ    = 2'b10,
        MODE_EQ_B  = 2'b11
    } mode_e;

endpackage

// File: rtl/run_detector_ch.sv
// One channel of the run detector: Moore FSM with a saturating
// run counter and a registered rising-edge pulse on detect.
module run_detector_ch
    import run_detector_pkg::*;
#(
    parameter int MAX_RUN = 8,
    parameter int CW      = $clog2(MAX_RUN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic [1:0]    mode,
    input  logic          overlap,
    input  logic [CW-1:0] eff_len,
    input  logic          w,
    output logic          z,
    output logic          det_pulse
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_RUN);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] inc;
    logic          eq_mode;
    logic          qual;
    logic          one;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        pulse_d = 1'b0;
        inc     = (cnt_q >= MAX_C) ? MAX_C : cnt_q + ONE_C;
        eq_mode = mode[1];
        qual    = eq_mode ? (w == prev_q) : (w ^ mode[0]);
        one     = (eff_len == ONE_C);
        if (en) begin
            if (clear) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                prev_d = w;
                // eq modes: a new value always (re)starts a run
                if (state_q == IDLE || (eq_mode && !qual)) begin
                    if (eq_mode || qual) begin
                        cnt_d   = ONE_C;
                        state_d = one ? DETECT : RUN;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!qual) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (state_q == DETECT) begin
                    if (overlap) begin
                        cnt_d = inc;
                    end else begin
                        cnt_d   = ONE_C;
                        state_d = one ? DETECT : RUN;
                    end
                end else begin
                    cnt_d   = inc;
                    state_d = (inc >= eff_len) ? DETECT : RUN;
                end
            end
            pulse_d = (state_d == DETECT) && (state_q != DETECT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign z         = (state_q == DETECT);
    assign det_pulse = pulse_q;

endmodule

// File: rtl/run_detector.sv
// Multi-channel run detector: clamps run_len, detects mode
// changes between sampled edges and fans out to the channels.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MAX_RUN = 8,
    parameter int CW      = $clog2(MAX_RUN + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic           overlap,
    input  logic [CW-1:0]  run_len,
    input  logic [NCH-1:0] w,
    output logic [NCH-1:0] z,
    output logic [NCH-1:0] det_pulse,
    output logic           any_z
);

    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] eff_len;
    logic          clear;

    always_comb begin
        eff_len = run_len;
        if (run_len == '0) begin
            eff_len = CW'(1);
        end else if (run_len > CW'(MAX_RUN)) begin
            eff_len = CW'(MAX_RUN);
        end
        mode_d = en ? mode : mode_q;
        clear  = (mode != mode_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_ONES;
        end else begin
            mode_q <= mode_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        run_detector_ch #(
            .MAX_RUN (MAX_RUN),
            .CW      (CW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .clear     (clear),
            .mode      (mode),
            .overlap   (overlap),
            .eff_len   (eff_len),
            .w         (w[i]),
            .z         (z[i]),
            .det_pulse (det_pulse[i])
        );
    end

    // z comes straight from the state flops, so this is glitch-safe
    assign any_z = |z;

endmodule

// File: tb/tb_run_detector.sv
// Random and directed stimulus for run_detector, compared each
// cycle against an integer run-count reference model.
module tb_run_detector;

    localparam int NCH     = 4;
    localparam int MAX_RUN = 8;
    localparam int CW      = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic           overlap = 1'b0;
    logic [CW-1:0]  run_len = '0;
    logic [NCH-1:0] w = '0;
    logic [NCH-1:0] z;
    logic [NCH-1:0] det_pulse;
    logic           any_z;

    run_detector #(
        .NCH     (NCH),
        .MAX_RUN (MAX_RUN),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .overlap   (overlap),
        .run_len   (run_len),
        .w         (w),
        .z         (z),
        .det_pulse (det_pulse),
        .any_z     (any_z)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int             cnt_m [NCH];
    bit             inrun [NCH];
    bit             prv   [NCH];
    logic [NCH-1:0] zm;
    logic [NCH-1:0] pm;
    logic [1:0]     lastm;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t",
                      tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            cnt_m[i] = 0;
            inrun[i] = 0;
            prv[i]   = 0;
        end
        zm    = '0;
        pm    = '0;
        lastm = 2'b00;
    endtask

    // One sampled edge: run length counted as plain integers.
    task automatic model_edge();
        int  len;
        bit  b, q, old;
        pm = '0;
        if (!en) return;
        len = (run_len == 0) ? 1 :
              (run_len > MAX_RUN) ? MAX_RUN : int'(run_len);
        if (mode != lastm) begin
            lastm = mode;
            model_reset_runs();
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            old = zm[i];
            b   = w[i];
            if (mode[1]) q = inrun[i] && (b == prv[i]);
            else         q = mode[0] ? !b : b;
            if (!mode[1] && !q) begin
                inrun[i] = 0;
                cnt_m[i] = 0;
                zm[i]    = 0;
            end else if (!q || !inrun[i]) begin
                inrun[i] = 1;
                cnt_m[i] = 1;
                zm[i]    = (len == 1);
            end else if (zm[i] && overlap) begin
                if (cnt_m[i] < MAX_RUN) cnt_m[i]++;
            end else if (zm[i]) begin
                cnt_m[i] = 1;
                zm[i]    = (len == 1);
            end else begin
                if (cnt_m[i] < MAX_RUN) cnt_m[i]++;
                zm[i] = (cnt_m[i] >= len);
            end
            prv[i] = b;
            pm[i]  = zm[i] && !old;
        end
    endtask

    task automatic model_reset_runs();
        for (int i = 0; i < NCH; i++) begin
            inrun[i] = 0;
            cnt_m[i] = 0;
        end
        zm = '0;
        pm = '0;
    endtask

    task automatic check_all(string tag);
        check({tag, "_z"}, 32'(z), 32'(zm));
        check({tag, "_p"}, 32'(det_pulse), 32'(pm));
        check({tag, "_any"}, 32'(any_z), 32'(|zm));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        tick("rst_hold");
        reset = 1'b0;
    endtask

    task automatic set_in(logic [1:0] m, logic [CW-1:0] rl,
                          logic o, logic e, logic [NCH-1:0] wv);
        mode    = m;
        run_len = rl;
        overlap = o;
        en      = e;
        w       = wv;
    endtask

    logic [4:0] w0_seq;
    logic [4:0] z0_exp;
    logic [4:0] p0_exp;
    logic [6:0] z1_exp;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // ch0 w=0,1,1,1,0 with run_len=2, overlap
        w0_seq = 5'b01110;
        z0_exp = 5'b00110;
        p0_exp = 5'b00100;
        for (int k = 0; k < 5; k++) begin
            set_in(2'b00, 4'd2, 1'b1, 1'b1, {3'b000, w0_seq[4-k]});
            tick("r031");
            check("r031_z0", 32'(z[0]), 32'(z0_exp[4-k]));
            check("r031_p0", 32'(det_pulse[0]), 32'(p0_exp[4-k]));
        end

        // ch1 ones for 7 edges, run_len=3, no overlap
        z1_exp = 7'b0010010;
        for (int k = 0; k < 7; k++) begin
            set_in(2'b00, 4'd3, 1'b0, 1'b1, 4'b0010);
            tick("r032");
            check("r032_z1", 32'(z[1]), 32'(z1_exp[6-k]));
            check("r032_p1", 32'(det_pulse[1]), 32'(z1_exp[6-k]));
        end

        // equal-value mode on ch2
        set_in(2'b10, 4'd3, 1'b1, 1'b1, 4'b0000);
        tick("r033_mc");
        for (int k = 0; k < 6; k++) begin
            w = (k < 2) ? 4'b0100 : 4'b0000;
            tick("r033");
        end

        // run_len clamping
        for (int k = 0; k < 3; k++) begin
            set_in(2'b00, 4'd0, 1'b0, 1'b1, 4'b1111);
            tick("r034_len0");
        end
        for (int k = 0; k < 9; k++) begin
            set_in(2'b00, 4'd15, 1'b1, 1'b1, (k == 0) ? 4'h0 : 4'hf);
            tick("r034_len15");
        end

        // reset mid-run, then mode change mid-run
        set_in(2'b00, 4'd3, 1'b1, 1'b1, 4'b0000);
        tick("r035");
        w = 4'hf;
        tick("r035");
        tick("r035");
        do_reset();
        for (int k = 0; k < 3; k++) begin
            w = 4'hf;
            tick("r035_rst");
        end
        w = 4'h0;
        tick("r035");
        w = 4'hf;
        tick("r035");
        tick("r035");
        mode = 2'b11;
        tick("r035_mc");
        mode = 2'b00;
        for (int k = 0; k < 4; k++) tick("r035_mc2");

        // en gap inside a run
        w = 4'h0;
        tick("r036");
        w = 4'hf;
        tick("r036");
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = 4'(k);
            tick("r036_hold");
        end
        en = 1'b1;
        w  = 4'hf;
        for (int k = 0; k < 3; k++) tick("r036_resume");

        // random traffic with occasional config changes and resets
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)
                run_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0)
                overlap = 1'($urandom_range(0, 1));
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0)
                    w[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter NCH, default 4, number of independent input channels (1..32).
REQ-002 Parameter MAX_RUN, default 8, largest programmable run length (2..255); CW = $clog2(MAX_RUN+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample enable; when 0, w is ignored and all state holds.
REQ-006 mode  input  2  qualifying rule: 00 run of ones, 01 run of zeros, 10 run of equal values, 11 same as 10.
REQ-007 overlap  input  1  1 = z stays high while the run continues; 0 = z is one cycle per completed run group.
REQ-008 run_len  input  CW  required run length; 0 treated as 1, values above MAX_RUN clamped to MAX_RUN.
REQ-009 w  input  NCH  per-channel serial data bit.
REQ-010 z  output  NCH  per-channel Moore detect output, registered.
REQ-011 det_pulse  output  NCH  per-channel one-cycle pulse on each 0->1 transition of z.
REQ-012 any_z  output  1  OR of z, registered with z.

Function
REQ-013 Each channel shall run an FSM with states IDLE, RUN, DETECT and a saturating counter cnt (CW bits, max MAX_RUN).
REQ-014 A sample is taken only on a clock edge with en=1; qualifying means w=1 (mode 00), w=0 (mode 01), or w equal to the previous sampled w (modes 10/11).
REQ-015 Modes 10/11: the first sample after IDLE starts a run with cnt=1; a sample that differs from the previous one restarts a run with cnt=1 and stores the new value.
REQ-016 Modes 00/01: a non-qualifying sample shall force IDLE with cnt=0 from any state.
REQ-017 IDLE -> RUN (cnt=1) on a qualifying sample; RUN increments cnt on a qualifying sample; entry to DETECT occurs when the incremented cnt reaches the effective run_len.
REQ-018 Effective run_len=1: a single qualifying sample goes IDLE -> DETECT directly.
REQ-019 z shall be 1 exactly while the channel is in DETECT; z rises on the clock edge that samples the run_len-th consecutive qualifying bit (zero added latency beyond the state register).
REQ-020 overlap=1: DETECT holds on further qualifying samples with cnt saturating at MAX_RUN.
REQ-021 overlap=0: from DETECT, a qualifying sample moves to RUN with cnt=1 (or stays in DETECT if effective run_len=1), so z pulses once per run_len qualifying samples.
REQ-022 det_pulse shall be 1 for one cycle on the edge where z goes 0->1; with run_len=1 and overlap=0 and continuous qualifying input, z stays high and det_pulse fires once.
REQ-023 A change of mode between consecutive sampled edges shall return every channel to IDLE with cnt=0 on the next edge, ignoring that edge's sample.
REQ-024 A change of run_len or overlap shall take effect at the next edge without clearing state; if cnt already reaches or exceeds the new effective run_len on a qualifying sample, the channel enters DETECT.
REQ-025 With en=0, z, det_pulse (forced 0), cnt and state shall hold; det_pulse shall never be high in a cycle after an en=0 edge.
REQ-026 Channels shall be fully independent; simultaneous detections on several channels shall all be reported in the same cycle.

Reset
REQ-027 reset=1 shall immediately force all channels to IDLE, cnt=0, stored previous value 0, z=0, det_pulse=0, any_z=0, and a stored mode of 00.
REQ-028 Reset asserted mid-run shall discard the run; the first qualifying sample after release counts as cnt=1.

Structure
REQ-029 Package run_detector_pkg shall hold the state enum (IDLE, RUN, DETECT) and the mode enum/constants.
REQ-030 The per-channel FSM shall be the sub-module run_detector_ch, instantiated NCH times by a generate loop; the top level holds run_len clamping, mode-change detection and any_z.

Verification
REQ-031 NCH=4, MAX_RUN=8, mode 00, run_len=2, overlap=1, ch0 w=0,1,1,1,0 -> z0=0,0,1,1,0; det_pulse0 high only on the third edge.
REQ-032 mode 00, run_len=3, overlap=0, ch1 w=1 for 7 edges -> z1 high on edges 3 and 6 only, det_pulse1 matching.
REQ-033 mode 10, run_len=3, ch2 w=1,1,0,0,0,0 -> z2 high on edges 5 and 6; no detection on the 1,1 run.
REQ-034 run_len=0 and run_len=15 -> behave as 1 and 8 respectively; with 8 ones and overlap=1, z rises on the eighth edge.
REQ-035 reset pulsed after 2 of 3 qualifying ones, or mode changed mid-run -> z stays 0 until 3 fresh qualifying samples.
REQ-036 en=0 for 4 edges inside a run of ones, run_len=3 -> count resumes and z rises on the third enabled qualifying edge; all outputs hold while en=0.
